// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment bit positions and hex font shared by the scan driver
package seg_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Entry n is the abcdefg pattern for hex digit n; listed F down to 0.
    localparam logic [15:0][6:0] HEX_FONT = {
        7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
        7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
        7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
        7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
    };

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational nibble to abcdefg segment pattern
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    assign segs = HEX_FONT[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multi-digit 7-segment scan driver with double-buffered frames
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIGITS    = 8,
    parameter int SCAN_DIV    = 50000,
    parameter int SEG_ACT_LOW = 0,
    parameter int DIG_ACT_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  lz_en,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4*N_DIGITS-1:0] wr_data,
    input  logic [N_DIGITS-1:0]   wr_dp,
    input  logic [N_DIGITS-1:0]   wr_blank,
    output logic [7:0]            seg,
    output logic [N_DIGITS-1:0]   dig_sel,
    output logic                  frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    frame_done_q, frame_done_d;
    logic                    pend_full_q, pend_full_d;
    logic [4*N_DIGITS-1:0]   pend_data_q, pend_data_d;
    logic [N_DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic [N_DIGITS-1:0]     pend_blank_q, pend_blank_d;
    logic [4*N_DIGITS-1:0]   act_data_q, act_data_d;
    logic [N_DIGITS-1:0]     act_dp_q, act_dp_d;
    logic [N_DIGITS-1:0]     act_blank_q, act_blank_d;
    logic [7:0]              seg_q, seg_d;
    logic [N_DIGITS-1:0]     dig_q, dig_d;

    logic                    tick;
    logic                    wrap;
    logic                    zero_run;
    logic [N_DIGITS-1:0]     supp;
    logic [3:0]              cur_nib;
    logic [6:0]              cur_font;
    logic                    cur_dp;
    logic                    cur_off;

    assign tick = en && (presc_q == PRESC_LAST);
    assign wrap = tick && (idx_q == IDX_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
            pend_full_q  <= 1'b0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
            seg_q        <= '0;
            dig_q        <= '0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
            pend_full_q  <= pend_full_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
        end
    end

    always_comb begin
        presc_d      = presc_q;
        idx_d        = idx_q;
        frame_done_d = wrap;
        if (en) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        end
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
    end

    // Commit only at a frame boundary so the visible frame never mixes two writes.
    always_comb begin
        pend_full_d  = pend_full_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        if (wrap && pend_full_q) begin
            act_data_d  = pend_data_q;
            act_dp_d    = pend_dp_q;
            act_blank_d = pend_blank_q;
            pend_full_d = 1'b0;
        end else if (wr_valid && !pend_full_q) begin
            pend_data_d  = wr_data;
            pend_dp_d    = wr_dp;
            pend_blank_d = wr_blank;
            pend_full_d  = 1'b1;
        end
    end

    assign wr_ready = !pend_full_q;

    always_comb begin
        zero_run = 1'b1;
        supp     = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (act_data_q[4*i +: 4] == 4'h0);
            supp[i]  = lz_en && zero_run && (i != 0);
        end
    end

    assign cur_nib = act_data_q[4*int'(idx_q) +: 4];
    assign cur_dp  = act_dp_q[idx_q];
    assign cur_off = act_blank_q[idx_q] || (supp[idx_q] && !cur_dp);

    seg_hex_decode u_hex_decode (
        .nibble (cur_nib),
        .segs   (cur_font)
    );

    always_comb begin
        seg_d = '0;
        dig_d = '0;
        if (en && !cur_off) begin
            dig_d[idx_q] = 1'b1;
            if (supp[idx_q]) begin
                seg_d[SEG_DP] = 1'b1;
            end else begin
                seg_d = {cur_font, cur_dp};
            end
        end
    end

    assign seg        = (SEG_ACT_LOW != 0) ? ~seg_q : seg_q;
    assign dig_sel    = (DIG_ACT_LOW != 0) ? ~dig_q : dig_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl (4 digits, divide-by-4)
module tb_seg_scan_ctrl;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst, en, lz_en, wr_valid;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp, wr_blank;
    logic        rdy_hi, rdy_lo, fd_hi, fd_lo;
    logic [7:0]  seg_hi, seg_lo;
    logic [3:0]  dig_hi, dig_lo;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.N_DIGITS(N), .SCAN_DIV(DIV), .SEG_ACT_LOW(0), .DIG_ACT_LOW(0)) u_dut_hi (
        .clk(clk), .rst(rst), .en(en), .lz_en(lz_en), .wr_valid(wr_valid), .wr_ready(rdy_hi),
        .wr_data(wr_data), .wr_dp(wr_dp), .wr_blank(wr_blank), .seg(seg_hi), .dig_sel(dig_hi),
        .frame_done(fd_hi));

    seg_scan_ctrl #(.N_DIGITS(N), .SCAN_DIV(DIV), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)) u_dut_lo (
        .clk(clk), .rst(rst), .en(en), .lz_en(lz_en), .wr_valid(wr_valid), .wr_ready(rdy_lo),
        .wr_data(wr_data), .wr_dp(wr_dp), .wr_blank(wr_blank), .seg(seg_lo), .dig_sel(dig_lo),
        .frame_done(fd_lo));

    // Reference model: scan position derived from the number of enabled cycles.
    int          m_en_cnt;
    logic        m_pend_full;
    logic [15:0] m_pend_data, m_act_data;
    logic [3:0]  m_pend_dp, m_pend_blank, m_act_dp, m_act_blank;
    logic [7:0]  m_seg;
    logic [3:0]  m_dig;
    logic        m_fd;

    typedef struct {
        logic [15:0]     data;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic            lz;
        logic [3:0][7:0] seg;
        logic [3:0][3:0] dig;
    } vec_t;

    vec_t tbl[4];

    function automatic logic [6:0] font_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    function automatic logic [11:0] expect_slot(input int slot);
        logic [3:0] nib;
        logic [3:0] dg;
        bit         sup;
        nib = 4'((m_act_data >> (4 * slot)) & 16'h000F);
        sup = lz_en && (slot != 0) && ((m_act_data >> (4 * slot)) == 16'h0);
        dg  = 4'(1 << slot);
        if (m_act_blank[slot] || (sup && !m_act_dp[slot])) return 12'h000;
        if (sup) return {dg, 8'h01};
        return {dg, font_of(nib), m_act_dp[slot]};
    endfunction

    task automatic model_reset();
        m_en_cnt     = 0;
        m_pend_full  = 1'b0;
        m_pend_data  = '0;
        m_pend_dp    = '0;
        m_pend_blank = '0;
        m_act_data   = '0;
        m_act_dp     = '0;
        m_act_blank  = 4'hF;
        m_seg        = '0;
        m_dig        = '0;
        m_fd         = 1'b0;
    endtask

    task automatic model_edge();
        int          slot;
        bit          tick, wrap;
        logic [11:0] p;
        slot = (m_en_cnt / DIV) % N;
        tick = en && ((m_en_cnt % DIV) == DIV - 1);
        wrap = tick && (slot == N - 1);
        p    = en ? expect_slot(slot) : 12'h000;
        m_seg = p[7:0];
        m_dig = p[11:8];
        m_fd  = wrap;
        if (wrap && m_pend_full) begin
            m_act_data  = m_pend_data;
            m_act_dp    = m_pend_dp;
            m_act_blank = m_pend_blank;
            m_pend_full = 1'b0;
        end else if (wr_valid && !m_pend_full) begin
            m_pend_data  = wr_data;
            m_pend_dp    = wr_dp;
            m_pend_blank = wr_blank;
            m_pend_full  = 1'b1;
        end
        if (en) m_en_cnt++;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [7:0] inv_seg;
        logic [3:0] inv_dig;
        inv_seg = ~m_seg;
        inv_dig = ~m_dig;
        check("seg", 16'(seg_hi), 16'(m_seg));
        check("dig_sel", 16'(dig_hi), 16'(m_dig));
        check("wr_ready", 16'(rdy_hi), 16'(!m_pend_full));
        check("frame_done", 16'(fd_hi), 16'(m_fd));
        check("seg_pin_low", 16'(seg_lo), 16'(inv_seg));
        check("dig_pin_low", 16'(dig_lo), 16'(inv_dig));
    endtask

    task automatic step();
        if (!rst) model_reset();
        else model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (!rdy_hi && n < budget) begin
            step();
            n++;
        end
        check("ready_timeout", 16'(rdy_hi), 16'd1);
    endtask

    task automatic write_frame(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        wait_ready(100);
        wr_data  = d;
        wr_dp    = dp;
        wr_blank = bl;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
    endtask

    initial begin
        int fd_count, xfers, held;

        tbl[0].data = 16'h12AF; tbl[0].dp = 4'b0000; tbl[0].blank = 4'b0000; tbl[0].lz = 1'b0;
        tbl[0].seg[0] = 8'b10001110; tbl[0].dig[0] = 4'b0001;
        tbl[0].seg[1] = 8'b11101110; tbl[0].dig[1] = 4'b0010;
        tbl[0].seg[2] = 8'b11011010; tbl[0].dig[2] = 4'b0100;
        tbl[0].seg[3] = 8'b01100000; tbl[0].dig[3] = 4'b1000;
        tbl[1].data = 16'h0070; tbl[1].dp = 4'b1000; tbl[1].blank = 4'b0000; tbl[1].lz = 1'b1;
        tbl[1].seg[0] = 8'b11111100; tbl[1].dig[0] = 4'b0001;
        tbl[1].seg[1] = 8'b11100000; tbl[1].dig[1] = 4'b0010;
        tbl[1].seg[2] = 8'h00;       tbl[1].dig[2] = 4'b0000;
        tbl[1].seg[3] = 8'h01;       tbl[1].dig[3] = 4'b1000;
        tbl[2].data = 16'h3B70; tbl[2].dp = 4'b1010; tbl[2].blank = 4'b0101; tbl[2].lz = 1'b0;
        tbl[2].seg[0] = 8'h00;       tbl[2].dig[0] = 4'b0000;
        tbl[2].seg[1] = 8'b11100001; tbl[2].dig[1] = 4'b0010;
        tbl[2].seg[2] = 8'h00;       tbl[2].dig[2] = 4'b0000;
        tbl[2].seg[3] = 8'b11110011; tbl[2].dig[3] = 4'b1000;
        tbl[3].data = 16'h0000; tbl[3].dp = 4'b0000; tbl[3].blank = 4'b0000; tbl[3].lz = 1'b1;
        tbl[3].seg[0] = 8'b11111100; tbl[3].dig[0] = 4'b0001;
        tbl[3].seg[1] = 8'h00;       tbl[3].dig[1] = 4'b0000;
        tbl[3].seg[2] = 8'h00;       tbl[3].dig[2] = 4'b0000;
        tbl[3].seg[3] = 8'h00;       tbl[3].dig[3] = 4'b0000;

        rst = 1'b0; en = 1'b0; lz_en = 1'b0; wr_valid = 1'b0;
        wr_data = '0; wr_dp = '0; wr_blank = '0;
        model_reset();
        step();
        step();
        rst = 1'b1;

        // Dark display after reset; frame_done every 16 enabled cycles.
        en = 1'b1;
        fd_count = 0;
        for (int i = 0; i < 48; i++) begin
            step();
            if (fd_hi) fd_count++;
        end
        check("frame_done_count", 16'(fd_count), 16'd3);

        // Table: write, wait for commit, then read one full frame slot by slot.
        for (int e = 0; e < 4; e++) begin
            lz_en = tbl[e].lz;
            write_frame(tbl[e].data, tbl[e].dp, tbl[e].blank);
            check("ready_drop", 16'(rdy_hi), 16'd0);
            wait_ready(100);
            step();
            for (int s = 0; s < N; s++) begin
                check("tbl_seg", 16'(seg_hi), 16'(tbl[e].seg[s]));
                check("tbl_dig", 16'(dig_hi), 16'(tbl[e].dig[s]));
                for (int k = 0; k < DIV; k++) step();
            end
        end

        // Second offer held while pending is full: exactly one transfer.
        lz_en = 1'b0;
        write_frame(16'h4567, 4'b0001, 4'b0000);
        wr_data = 16'h89AB; wr_dp = 4'b0010; wr_blank = 4'b0000;
        wr_valid = 1'b1;
        xfers = 0;
        held = 0;
        for (int i = 0; i < 60 && xfers == 0; i++) begin
            if (wr_valid && rdy_hi) xfers++;
            else held++;
            step();
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (wr_valid && rdy_hi) xfers++;
            step();
        end
        check("held_xfers", 16'(xfers), 16'd1);
        check("held_wait", 16'(held > 0), 16'd1);

        // en=0: scan freezes, outputs go inactive, handshake continues.
        en = 1'b0;
        for (int i = 0; i < 10; i++) step();
        write_frame(16'hC0DE, 4'b0100, 4'b0000);
        for (int i = 0; i < 20; i++) step();
        en = 1'b1;
        for (int i = 0; i < 40; i++) step();

        // Asynchronous reset with a frame pending.
        write_frame(16'h1111, 4'b1111, 4'b0000);
        step();
        #2;
        rst = 1'b0;
        #1;
        check("rst_seg", 16'(seg_hi), 16'h0000);
        check("rst_dig", 16'(dig_hi), 16'h0000);
        check("rst_ready", 16'(rdy_hi), 16'd1);
        check("rst_seg_low", 16'(seg_lo), 16'h00FF);
        check("rst_dig_low", 16'(dig_lo), 16'h000F);
        check("rst_fd", 16'(fd_hi), 16'd0);
        model_reset();
        step();
        rst = 1'b1;
        for (int i = 0; i < 40; i++) step();

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            en       = ($urandom_range(0, 7) != 0);
            wr_valid = ($urandom_range(0, 3) == 0);
            wr_data  = 16'($urandom) & (($urandom_range(0, 1) != 0) ? 16'h00FF : 16'hFFFF);
            wr_dp    = 4'($urandom);
            wr_blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
